sd_average_n: RTL and testbench

SD_AVERAGE_N -- requirements
Module: sd_average_n

---
 rtl/sd_average_n.sv | 107 ++++++++++
 tb/tb_sd_average_n.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sd_average_n.sv
// sd_average_n: averages CHANNELS masked 1-bit sigma-delta streams into one
// sigma-delta stream, and decimates the masked ones-count into a PCM word.
module sd_average_n #(
  parameter int                  CHANNELS   = 4,
  parameter int                  DECIM_LOG2 = 4,
  parameter logic [CHANNELS-1:0] MASK_INIT  = '1,
  localparam int                 CW         = $clog2(CHANNELS+1),
  localparam int                 W          = CW + DECIM_LOG2,
  localparam int                 AW         = CW + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CHANNELS-1:0] in,
  input  logic [CHANNELS-1:0] mask_in,
  input  logic                mask_load,
  output logic                sd_out,
  output logic [W-1:0]        pcm_out,
  output logic                pcm_valid
);

  logic [CHANNELS-1:0]   mask_q, mask_d;
  logic [AW-1:0]         acc_q, acc_d;
  logic [DECIM_LOG2-1:0] wcnt_q, wcnt_d;
  logic [W-1:0]          wsum_q, wsum_d;
  logic [W-1:0]          pcm_q, pcm_d;
  logic                  sd_q, sd_d;
  logic                  vld_q, vld_d;

  logic [CW-1:0] ones, m;
  logic [AW-1:0] sum;

  // Popcounts of the live mask and of the masked input bits.
  always_comb begin
    ones = '0;
    m    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      ones = ones + CW'(in[i] & mask_q[i]);
      m    = m + CW'(mask_q[i]);
    end
  end

  // Next state: mask reload beats sampling; otherwise error-feedback
  // modulator plus window accumulator advance on enabled cycles.
  always_comb begin
    mask_d = mask_q;
    acc_d  = acc_q;
    wcnt_d = wcnt_q;
    wsum_d = wsum_q;
    pcm_d  = pcm_q;
    sd_d   = sd_q;
    vld_d  = 1'b0;
    sum    = acc_q + AW'(ones);
    if (mask_load) begin
      // Sample in this cycle is dropped; partial window is thrown away.
      mask_d = mask_in;
      acc_d  = '0;
      wcnt_d = '0;
      wsum_d = '0;
    end else if (en) begin
      if (m == '0) begin
        sd_d  = 1'b0;
        acc_d = '0;
      end else if (sum >= AW'(m)) begin
        sd_d  = 1'b1;
        acc_d = sum - AW'(m);
      end else begin
        sd_d  = 1'b0;
        acc_d = sum;
      end
      wcnt_d = wcnt_q + 1'b1;
      if (wcnt_q == '1) begin
        pcm_d  = wsum_q + W'(ones);
        vld_d  = 1'b1;
        wsum_d = '0;
      end else begin
        wsum_d = wsum_q + W'(ones);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mask_q <= MASK_INIT;
      acc_q  <= '0;
      wcnt_q <= '0;
      wsum_q <= '0;
      pcm_q  <= '0;
      sd_q   <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      acc_q  <= acc_d;
      wcnt_q <= wcnt_d;
      wsum_q <= wsum_d;
      pcm_q  <= pcm_d;
      sd_q   <= sd_d;
      vld_q  <= vld_d;
    end
  end

  assign sd_out    = sd_q;
  assign pcm_out   = pcm_q;
  assign pcm_valid = vld_q;

endmodule

// File: tb/tb_sd_average_n.sv
// Directed bench for sd_average_n (CHANNELS=4, DECIM_LOG2=4).
module tb_sd_average_n;
  logic       clk = 1'b0;
  logic       rst, en, mask_load;
  logic [3:0] in_b, mask_in;
  logic       sd_out, pcm_valid;
  logic [6:0] pcm_out;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sd_average_n #(.CHANNELS(4), .DECIM_LOG2(4), .MASK_INIT(4'hF)) dut (
    .clk(clk), .rst(rst), .en(en), .in(in_b), .mask_in(mask_in),
    .mask_load(mask_load), .sd_out(sd_out), .pcm_out(pcm_out),
    .pcm_valid(pcm_valid)
  );

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0; en = 1'b0; mask_load = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0; en = 1'b1; mask_load = 1'b1; mask_in = 4'h0; in_b = 4'hF;
    tick();
    n_cmp++; if (sd_out !== 1'b0) begin n_bad++; $display("FAIL reset_sd got %b want 0", sd_out); end
    n_cmp++; if (pcm_out !== 7'd0) begin n_bad++; $display("FAIL reset_pcm got %0d want 0", pcm_out); end
    n_cmp++; if (pcm_valid !== 1'b0) begin n_bad++; $display("FAIL reset_vld got %b want 0", pcm_valid); end
    // Reset must have won over mask_load: MASK_INIT active, so full input gives 1.
    rst = 1'b1; mask_load = 1'b0;
    tick();
    n_cmp++; if (sd_out !== 1'b1) begin n_bad++; $display("FAIL reset_prio_sd got %b want 1", sd_out); end
  endtask

  task automatic test_full;
    do_reset();
    en = 1'b1; in_b = 4'hF;
    for (int k = 1; k <= 32; k++) begin
      tick();
      n_cmp++; if (sd_out !== 1'b1) begin n_bad++; $display("FAIL full_sd k=%0d got %b want 1", k, sd_out); end
      n_cmp++; if (pcm_valid !== (k % 16 == 0)) begin n_bad++; $display("FAIL full_vld k=%0d got %b", k, pcm_valid); end
      n_cmp++; if (pcm_out !== ((k >= 16) ? 7'd64 : 7'd0)) begin n_bad++; $display("FAIL full_pcm k=%0d got %0d", k, pcm_out); end
    end
  endtask

  task automatic test_half;
    do_reset();
    en = 1'b1; in_b = 4'b0011;
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_cmp++; if (sd_out !== (k % 2 == 0)) begin n_bad++; $display("FAIL half_sd k=%0d got %b", k, sd_out); end
      n_cmp++; if (pcm_valid !== (k == 16)) begin n_bad++; $display("FAIL half_vld k=%0d got %b", k, pcm_valid); end
    end
    n_cmp++; if (pcm_out !== 7'd32) begin n_bad++; $display("FAIL half_pcm got %0d want 32", pcm_out); end
  endtask

  task automatic test_mask;
    do_reset();
    en = 1'b1; in_b = 4'hF;
    tick();
    // Load with en high: sample dropped, sd_out keeps its 1.
    mask_load = 1'b1; mask_in = 4'b0011;
    tick();
    n_cmp++; if (sd_out !== 1'b1) begin n_bad++; $display("FAIL mask_hold_sd got %b want 1", sd_out); end
    n_cmp++; if (pcm_valid !== 1'b0) begin n_bad++; $display("FAIL mask_hold_vld got %b want 0", pcm_valid); end
    mask_load = 1'b0; in_b = 4'b0001;
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_cmp++; if (sd_out !== (k % 2 == 0)) begin n_bad++; $display("FAIL mask2_sd k=%0d got %b", k, sd_out); end
      n_cmp++; if (pcm_valid !== (k == 16)) begin n_bad++; $display("FAIL mask2_vld k=%0d got %b", k, pcm_valid); end
    end
    n_cmp++; if (pcm_out !== 7'd16) begin n_bad++; $display("FAIL mask2_pcm got %0d want 16", pcm_out); end
    mask_load = 1'b1; mask_in = 4'b0000;
    tick();
    mask_load = 1'b0; in_b = 4'hF;
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_cmp++; if (sd_out !== 1'b0) begin n_bad++; $display("FAIL mask0_sd k=%0d got %b want 0", k, sd_out); end
      n_cmp++; if (pcm_valid !== (k == 16)) begin n_bad++; $display("FAIL mask0_vld k=%0d got %b", k, pcm_valid); end
      n_cmp++; if (pcm_out !== ((k == 16) ? 7'd0 : 7'd16)) begin n_bad++; $display("FAIL mask0_pcm k=%0d got %0d", k, pcm_out); end
    end
  endtask

  task automatic test_mask_same;
    do_reset();
    en = 1'b1; in_b = 4'b0011;
    for (int k = 0; k < 3; k++) tick();
    mask_load = 1'b1; mask_in = 4'hF;
    tick();
    mask_load = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_cmp++; if (sd_out !== (k % 2 == 0)) begin n_bad++; $display("FAIL same_sd k=%0d got %b", k, sd_out); end
      n_cmp++; if (pcm_valid !== (k == 16)) begin n_bad++; $display("FAIL same_vld k=%0d got %b", k, pcm_valid); end
    end
    n_cmp++; if (pcm_out !== 7'd32) begin n_bad++; $display("FAIL same_pcm got %0d want 32", pcm_out); end
  endtask

  task automatic test_en_toggle;
    int e = 0;
    do_reset();
    in_b = 4'hF;
    for (int i = 1; i <= 64; i++) begin
      en = (i % 2 == 1);
      tick();
      if (en) e++;
      n_cmp++; if (pcm_valid !== (en && e % 16 == 0)) begin n_bad++; $display("FAIL tog_vld i=%0d got %b", i, pcm_valid); end
      n_cmp++; if (pcm_out !== ((e >= 16) ? 7'd64 : 7'd0)) begin n_bad++; $display("FAIL tog_pcm i=%0d got %0d", i, pcm_out); end
      n_cmp++; if (sd_out !== 1'b1) begin n_bad++; $display("FAIL tog_sd i=%0d got %b want 1", i, sd_out); end
    end
  endtask

  task automatic test_mid_reset;
    do_reset();
    en = 1'b1; in_b = 4'hF;
    for (int k = 0; k < 10; k++) tick();
    rst = 1'b0;
    tick();
    n_cmp++; if ({sd_out, pcm_valid, pcm_out} !== 9'd0) begin n_bad++; $display("FAIL mid_rst got %b want 0", {sd_out, pcm_valid, pcm_out}); end
    rst = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      n_cmp++; if (pcm_valid !== (k == 16)) begin n_bad++; $display("FAIL mid_vld k=%0d got %b", k, pcm_valid); end
    end
  endtask

  task automatic test_two_dacs;
    int a0 = 0, a1 = 0, in_ones = 0, sd_cnt = 0;
    logic b0, b1;
    do_reset();
    mask_load = 1'b1; mask_in = 4'b0011;
    tick();
    mask_load = 1'b0; en = 1'b1;
    for (int k = 0; k < 256; k++) begin
      // First-order DACs with 4-bit commands -8 and +7 (density (cmd+8)/16).
      a0 += 0;  b0 = (a0 >= 16); if (b0) a0 -= 16;
      a1 += 15; b1 = (a1 >= 16); if (b1) a1 -= 16;
      in_b = {2'b00, b1, b0};
      in_ones += int'(b0) + int'(b1);
      tick();
      sd_cnt += int'(sd_out);
    end
    n_cmp++; if (sd_cnt < 119 || sd_cnt > 121) begin n_bad++; $display("FAIL dac_density got %0d want 120+-1", sd_cnt); end
    n_cmp++; if (2*sd_cnt > in_ones + 2 || 2*sd_cnt + 2 < in_ones) begin n_bad++; $display("FAIL dac_track got %0d want %0d/2", sd_cnt, in_ones); end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; mask_load = 1'b0; in_b = '0; mask_in = '0;
    tick();
    test_reset();
    test_full();
    test_half();
    test_mask();
    test_mask_same();
    test_en_toggle();
    test_mid_reset();
    test_two_dacs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
